// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: dual allocation, dual completion, dual retirement with free-list return.
// Define ROB_ASSERT_EN to compile the simulation-only consistency checks.
module reorder_buffer #(
    parameter int ROB_DEPTH   = 16,
    parameter int PHYS_ADDR_W = 6,
    parameter int TAG_W       = 4
) (
    input  logic                   clk,
    input  logic                   res,
    input  logic                   alloc_int_valid,
    input  logic [PHYS_ADDR_W-1:0] alloc_int_old_pd,
    input  logic                   alloc_ls_valid,
    input  logic                   alloc_ls_store,
    input  logic [PHYS_ADDR_W-1:0] alloc_ls_old_pd,
    output logic [TAG_W-1:0]       alloc_int_tag,
    output logic [TAG_W-1:0]       alloc_ls_tag,
    output logic                   rob_full,
    input  logic                   complete_int_valid,
    input  logic [TAG_W-1:0]       complete_int_tag,
    input  logic                   complete_ls_valid,
    input  logic [TAG_W-1:0]       complete_ls_tag,
    output logic [PHYS_ADDR_W-1:0] freeMeUp_0_rob2rat,
    output logic [PHYS_ADDR_W-1:0] freeMeUp_1_rob2rat,
    output logic [1:0]             commit_cnt
);

    localparam int PTR_W = TAG_W + 1;

    logic [ROB_DEPTH-1:0]   r_valid;
    logic [ROB_DEPTH-1:0]   r_done;
    logic [PHYS_ADDR_W-1:0] r_oldPd [ROB_DEPTH];
    logic [PTR_W-1:0]       r_head;
    logic [PTR_W-1:0]       r_tail;
    logic [PTR_W-1:0]       r_count;
    logic [PHYS_ADDR_W-1:0] r_free0;
    logic [PHYS_ADDR_W-1:0] r_free1;
    logic [1:0]             r_commitCnt;

    logic                   w_intAccept;
    logic                   w_lsAccept;
    logic [PTR_W-1:0]       w_tailPlusInt;
    logic [TAG_W-1:0]       w_intIdx;
    logic [TAG_W-1:0]       w_lsIdx;
    logic [1:0]             w_allocNum;
    logic [TAG_W-1:0]       w_headIdx;
    logic [TAG_W-1:0]       w_head1Idx;
    logic                   w_retire0;
    logic                   w_retire1;
    logic [1:0]             w_retireNum;
    logic [PHYS_ADDR_W-1:0] w_lsOldPd;
    logic [ROB_DEPTH-1:0]   w_validNext;
    logic [ROB_DEPTH-1:0]   w_doneNext;

    // Full threshold leaves room for a pair so it never depends on the alloc inputs.
    assign rob_full      = (r_count > PTR_W'(ROB_DEPTH - 2));
    assign w_intAccept   = alloc_int_valid & ~rob_full;
    assign w_lsAccept    = alloc_ls_valid & ~rob_full;
    assign w_tailPlusInt = r_tail + PTR_W'(alloc_int_valid);
    assign w_intIdx      = r_tail[TAG_W-1:0];
    assign w_lsIdx       = w_tailPlusInt[TAG_W-1:0];
    assign alloc_int_tag = w_intIdx;
    assign alloc_ls_tag  = w_lsIdx;
    assign w_allocNum    = {1'b0, w_intAccept} + {1'b0, w_lsAccept};
    assign w_lsOldPd     = alloc_ls_store ? '0 : alloc_ls_old_pd;

    assign w_headIdx     = r_head[TAG_W-1:0];
    assign w_head1Idx    = w_headIdx + TAG_W'(1);
    assign w_retire0     = r_valid[w_headIdx] & r_done[w_headIdx];
    assign w_retire1     = w_retire0 & r_valid[w_head1Idx] & r_done[w_head1Idx];
    assign w_retireNum   = {1'b0, w_retire0} + {1'b0, w_retire1};

    assign freeMeUp_0_rob2rat = r_free0;
    assign freeMeUp_1_rob2rat = r_free1;
    assign commit_cnt         = r_commitCnt;

    // Retire clears override a same-cycle completion; allocated slots never overlap occupied ones.
    always_comb begin
        w_validNext = r_valid;
        w_doneNext  = r_done;
        if (complete_int_valid && r_valid[complete_int_tag]) begin
            w_doneNext[complete_int_tag] = 1'b1;
        end
        if (complete_ls_valid && r_valid[complete_ls_tag]) begin
            w_doneNext[complete_ls_tag] = 1'b1;
        end
        if (w_retire0) begin
            w_validNext[w_headIdx] = 1'b0;
            w_doneNext[w_headIdx]  = 1'b0;
        end
        if (w_retire1) begin
            w_validNext[w_head1Idx] = 1'b0;
            w_doneNext[w_head1Idx]  = 1'b0;
        end
        if (w_intAccept) begin
            w_validNext[w_intIdx] = 1'b1;
            w_doneNext[w_intIdx]  = 1'b0;
        end
        if (w_lsAccept) begin
            w_validNext[w_lsIdx] = 1'b1;
            w_doneNext[w_lsIdx]  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_valid     <= '0;
            r_done      <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_free0     <= '0;
            r_free1     <= '0;
            r_commitCnt <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                r_oldPd[i] <= '0;
            end
        end else begin
            r_valid     <= w_validNext;
            r_done      <= w_doneNext;
            r_head      <= r_head + PTR_W'(w_retireNum);
            r_tail      <= r_tail + PTR_W'(w_allocNum);
            r_count     <= r_count + PTR_W'(w_allocNum) - PTR_W'(w_retireNum);
            r_free0     <= w_retire0 ? r_oldPd[w_headIdx] : '0;
            r_free1     <= w_retire1 ? r_oldPd[w_head1Idx] : '0;
            r_commitCnt <= w_retireNum;
            if (w_intAccept) begin
                r_oldPd[w_intIdx] <= alloc_int_old_pd;
            end
            if (w_lsAccept) begin
                r_oldPd[w_lsIdx] <= w_lsOldPd;
            end
        end
    end

`ifdef ROB_ASSERT_EN
    logic [PTR_W-1:0] w_ptrDiff;
    assign w_ptrDiff = r_tail - r_head;

    always @(posedge clk) begin
        if (!res) begin
            if ((alloc_int_valid || alloc_ls_valid) && rob_full)
                $error("reorder_buffer: allocation attempted while full");
            if (complete_int_valid && !r_valid[complete_int_tag])
                $error("reorder_buffer: int completion to invalid entry %0d", complete_int_tag);
            if (complete_ls_valid && !r_valid[complete_ls_tag])
                $error("reorder_buffer: ls completion to invalid entry %0d", complete_ls_tag);
            if (r_count != w_ptrDiff)
                $error("reorder_buffer: count %0d disagrees with tail-head %0d", r_count, w_ptrDiff);
            if (alloc_ls_store && !alloc_ls_valid)
                $error("reorder_buffer: store flag without ls allocation");
        end
    end
`else
    // Checks compiled out; datapath is unchanged.
`endif

endmodule
